dmem_access_ctrl: RTL

- Multi-cycle sequencer between the MEM pipeline stage and a synchronous data memory.
- Executes every `dmem_access` code as a timed sequence of word-aligned memory transactions.
- Byte/halfword stores become read-modify-write (read word, merge lane, write word); loads get lane extraction and sign/zero extension.
- Asserts `stall` to freeze the pipeline until the access completes; flags misaligned accesses without touching memory.

---
 rtl/dmem_access_ctrl_if.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and memory-bus signals of the data-memory access sequencer.
// slave = the sequencer itself; master = pipeline stage plus memory side.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_access;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_access, req_addr, req_wdata, mem_rdata,
    output stall, resp_valid, resp_rdata, resp_misalign,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_access, req_addr, req_wdata, mem_rdata,
    input  stall, resp_valid, resp_rdata, resp_misalign,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle sequencer turning MEM-stage load/store codes into word-aligned
// memory transactions; sub-word stores are done as read-modify-write.
module dmem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [3:0] ACC_NONE  = 4'b0000;
  localparam logic [3:0] ACC_LD_BU = 4'b0001;
  localparam logic [3:0] ACC_LD_B  = 4'b0010;
  localparam logic [3:0] ACC_ST_B  = 4'b0011;
  localparam logic [3:0] ACC_LD_HU = 4'b0100;
  localparam logic [3:0] ACC_LD_W  = 4'b0110;
  localparam logic [3:0] ACC_LD_H  = 4'b1000;
  localparam logic [3:0] ACC_ST_W  = 4'b1001;
  localparam logic [3:0] ACC_ST_H  = 4'b1100;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic             mis_q, mis_d;

  // Access-code decode; request fields are held by the requester for the
  // whole sequence, so they are decoded live rather than registered.
  logic is_ld_bu, is_ld_b, is_ld_hu, is_ld_h, is_ld_w;
  logic is_st_b, is_st_h, is_st_w;
  logic is_load, is_sub_store, is_legal, req_active, misaligned;

  assign is_ld_bu     = (bus.req_access == ACC_LD_BU);
  assign is_ld_b      = (bus.req_access == ACC_LD_B);
  assign is_ld_hu     = (bus.req_access == ACC_LD_HU);
  assign is_ld_h      = (bus.req_access == ACC_LD_H);
  assign is_ld_w      = (bus.req_access == ACC_LD_W);
  assign is_st_b      = (bus.req_access == ACC_ST_B);
  assign is_st_h      = (bus.req_access == ACC_ST_H);
  assign is_st_w      = (bus.req_access == ACC_ST_W);
  assign is_load      = is_ld_bu | is_ld_b | is_ld_hu | is_ld_h | is_ld_w;
  assign is_sub_store = is_st_b | is_st_h;
  assign is_legal     = is_load | is_sub_store | is_st_w;
  assign req_active   = bus.req_valid && (bus.req_access != ACC_NONE);

  assign misaligned = !is_legal
                    || ((is_ld_w || is_st_w) && (bus.req_addr[1:0] != 2'b00))
                    || ((is_ld_hu || is_ld_h || is_st_h) && bus.req_addr[0]);

  logic [31:0] word_addr;
  assign word_addr = {bus.req_addr[31:2], 2'b00};

  // Lane extraction and extension for loads.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;

  assign sel_byte = rbuf_q[{bus.req_addr[1:0], 3'b000} +: 8];
  assign sel_half = bus.req_addr[1] ? rbuf_q[31:16] : rbuf_q[15:0];

  always_comb begin
    load_result = 32'd0;
    if (is_ld_w) begin
      load_result = rbuf_q;
    end else if (is_ld_bu) begin
      load_result = {24'd0, sel_byte};
    end else if (is_ld_b) begin
      load_result = {{24{sel_byte[7]}}, sel_byte};
    end else if (is_ld_hu) begin
      load_result = {16'd0, sel_half};
    end else if (is_ld_h) begin
      load_result = {{16{sel_half[15]}}, sel_half};
    end
  end

  // Store data per byte lane: full word for st_w, otherwise the read buffer
  // with only the addressed byte or half replaced.
  logic [31:0] merged_wdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic byte_hit;
    logic half_hit;
    assign byte_hit = is_st_b && (bus.req_addr[1:0] == 2'(gi));
    assign half_hit = is_st_h && (bus.req_addr[1] == (gi >= 2));
    assign merged_wdata[8*gi +: 8] =
        is_st_w  ? bus.req_wdata[8*gi +: 8] :
        byte_hit ? bus.req_wdata[7:0] :
        half_hit ? bus.req_wdata[8*(gi%2) +: 8] :
                   rbuf_q[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rbuf_q  <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (req_active) begin
          mis_d = misaligned;
          if (misaligned) begin
            state_d = S_RESP;
          end else if (is_st_w) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter hits zero in the very cycle the read data is valid.
        if (cnt_q == '0) begin
          rbuf_d  = bus.mem_rdata;
          state_d = is_sub_store ? S_WRITE : S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        mis_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.mem_en        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = 32'd0;
    bus.mem_wdata     = 32'd0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = 32'd0;
    bus.resp_misalign = 1'b0;
    case (state_q)
      S_READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = word_addr;
      end
      S_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = word_addr;
        bus.mem_wdata = merged_wdata;
      end
      S_RESP: begin
        bus.resp_valid    = 1'b1;
        bus.resp_misalign = mis_q;
        bus.resp_rdata    = mis_q ? 32'd0 : load_result;
      end
      default: begin
      end
    endcase
  end

  // Released in the RESP cycle so the pipeline advances on that edge.
  assign bus.stall = req_active && (state_q != S_RESP);

endmodule
